// File: rtl/mtr_pi_intf.sv
// Meter-to-PI interrupt interface: sticky meter events -> PI request -> one vector word per honor.
// Define MTR_PI_LOST_CNT_EN to implement the saturating lost-overflow counter (lost_cnt).
module mtr_pi_intf #(
    parameter int TIMEOUT = 64,
    parameter int LOST_W  = 8
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              cono_en,
    input  logic [2:0]        cono_pia,
    input  logic              ovf_time,
    input  logic              ovf_perf,
    input  logic              ovf_ebox,
    input  logic              ovf_cache,
    input  logic              interval_done,
    output logic              interval_ack,
    output logic              pi_req,
    output logic [2:0]        pi_req_pia,
    input  logic              pi_honor,
    output logic              vec_valid,
    output logic              vec_vector,
    output logic [1:0]        vec_func,
    input  logic              vec_ready,
    output logic [2:0]        mtr_pia,
    output logic [4:0]        pend,
    output logic [LOST_W-1:0] lost_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_VEC  = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    localparam int               TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [2:0]       SEL_INTV = 3'd4;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [2:0]       sel_q, sel_d;
    logic [3:0]       ovf_pend_q, ovf_pend_d;
    logic [2:0]       pia_q, pia_d;
    logic             int_mask_q, int_mask_d;
    logic             ack_q, ack_d;

    logic [3:0]       ovf_in;
    logic [4:0]       pend_all;
    logic [2:0]       top_sel;
    logic             req_ok;
    logic             retire;
    logic             retire_ovf;

    // Bit index doubles as the increment function code (time=0 .. cache=3).
    assign ovf_in   = {ovf_cache, ovf_ebox, ovf_perf, ovf_time};
    assign pend_all = {interval_done & ~int_mask_q, ovf_pend_q};

    always_comb begin
        top_sel = SEL_INTV;
        for (int i = 3; i >= 0; i--) begin
            if (ovf_pend_q[i]) top_sel = 3'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        tmr_d     = '0;
        pi_req    = 1'b0;
        vec_valid = 1'b0;
        retire    = 1'b0;
        req_ok    = (|pend_all) && (pia_q != 3'd0);
        case (state_q)
            ST_IDLE: begin
                if (req_ok) state_d = ST_REQ;
            end
            ST_REQ: begin
                pi_req = 1'b1;
                tmr_d  = tmr_q + 1'b1;
                if (pi_honor && (|pend_all)) begin
                    state_d = ST_VEC;
                    sel_d   = top_sel;
                end else if (!req_ok) begin
                    state_d = ST_IDLE;
                end else if (tmr_q == TMR_LAST) begin
                    state_d = ST_DROP;
                end
            end
            ST_VEC: begin
                vec_valid = 1'b1;
                if (vec_ready) begin
                    retire  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                // Single dead cycle: re-post straight away if work is still pending.
                state_d = req_ok ? ST_REQ : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign retire_ovf = retire && (sel_q != SEL_INTV);

    always_comb begin
        ovf_pend_d = ovf_pend_q | ovf_in;
        // A fresh pulse on the source being retired keeps its bit set.
        if (retire_ovf) ovf_pend_d[sel_q[1:0]] = ovf_in[sel_q[1:0]];

        int_mask_d = int_mask_q;
        if (retire && (sel_q == SEL_INTV)) begin
            int_mask_d = 1'b1;
        end else if (!interval_done) begin
            int_mask_d = 1'b0;
        end

        ack_d = retire && (sel_q == SEL_INTV);
        pia_d = cono_en ? cono_pia : pia_q;
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            ovf_pend_q <= '0;
            pia_q      <= '0;
            int_mask_q <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            ovf_pend_q <= ovf_pend_d;
            pia_q      <= pia_d;
            int_mask_q <= int_mask_d;
            ack_q      <= ack_d;
        end
    end

    // sel is only observed while vec_valid is high, so it needs no reset.
    always_ff @(posedge clk) begin
        sel_q <= sel_d;
    end

    assign interval_ack = ack_q;
    assign vec_vector   = vec_valid && (sel_q == SEL_INTV);
    assign vec_func     = (vec_valid && (sel_q != SEL_INTV)) ? sel_q[1:0] : 2'd0;
    assign mtr_pia      = pia_q;
    assign pi_req_pia   = pia_q;
    assign pend         = pend_all;

`ifdef MTR_PI_LOST_CNT_EN
    logic [LOST_W-1:0] lost_q, lost_d;
    logic [3:0]        lost_hit;
    logic [2:0]        lost_num;

    function automatic logic [LOST_W-1:0] sat_add(input logic [LOST_W-1:0] a,
                                                  input logic [2:0]        b);
        logic [LOST_W+2:0] sum;
        sum = {3'b000, a} + (LOST_W+3)'(b);
        if (sum > {3'b000, {LOST_W{1'b1}}}) return {LOST_W{1'b1}};
        return sum[LOST_W-1:0];
    endfunction

    always_comb begin
        lost_hit = ovf_in & ovf_pend_q;
        if (retire_ovf) lost_hit[sel_q[1:0]] = 1'b0;
        lost_num = 3'(lost_hit[0]) + 3'(lost_hit[1]) + 3'(lost_hit[2]) + 3'(lost_hit[3]);
        lost_d   = cono_en ? '0 : sat_add(lost_q, lost_num);
    end

    always_ff @(posedge clk) begin
        if (RESET) lost_q <= '0;
        else       lost_q <= lost_d;
    end

    assign lost_cnt = lost_q;
`else
    assign lost_cnt = '0;
`endif

endmodule

// File: tb/tb_mtr_pi_intf.sv
// Directed plan steps followed by a randomized phase scored against a pending-set model.
module tb_mtr_pi_intf;

    localparam int TIMEOUT = 4;
    localparam int LOST_W  = 8;
`ifdef MTR_PI_LOST_CNT_EN
    localparam bit LOST_EN = 1'b1;
`else
    localparam bit LOST_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              RESET = 1'b1;
    logic              cono_en = 1'b0;
    logic [2:0]        cono_pia = 3'd0;
    logic              ovf_time = 1'b0, ovf_perf = 1'b0, ovf_ebox = 1'b0, ovf_cache = 1'b0;
    logic              interval_done = 1'b0;
    logic              interval_ack;
    logic              pi_req;
    logic [2:0]        pi_req_pia;
    logic              pi_honor = 1'b0;
    logic              vec_valid;
    logic              vec_vector;
    logic [1:0]        vec_func;
    logic              vec_ready = 1'b0;
    logic [2:0]        mtr_pia;
    logic [4:0]        pend;
    logic [LOST_W-1:0] lost_cnt;

    int checks = 0;
    int errors = 0;

    mtr_pi_intf #(.TIMEOUT(TIMEOUT), .LOST_W(LOST_W)) dut (
        .clk(clk), .RESET(RESET), .cono_en(cono_en), .cono_pia(cono_pia),
        .ovf_time(ovf_time), .ovf_perf(ovf_perf), .ovf_ebox(ovf_ebox), .ovf_cache(ovf_cache),
        .interval_done(interval_done), .interval_ack(interval_ack),
        .pi_req(pi_req), .pi_req_pia(pi_req_pia), .pi_honor(pi_honor),
        .vec_valid(vec_valid), .vec_vector(vec_vector), .vec_func(vec_func),
        .vec_ready(vec_ready), .mtr_pia(mtr_pia), .pend(pend), .lost_cnt(lost_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cono(input logic [2:0] p);
        cono_en = 1'b1; cono_pia = p;
        step();
        cono_en = 1'b0;
    endtask

    // bits: {cache, ebox, perf, time}
    task automatic pulse(input logic [3:0] b);
        {ovf_cache, ovf_ebox, ovf_perf, ovf_time} = b;
        step();
        {ovf_cache, ovf_ebox, ovf_perf, ovf_time} = 4'b0;
    endtask

    task automatic honor();
        pi_honor = 1'b1; step(); pi_honor = 1'b0;
    endtask

    task automatic ready();
        vec_ready = 1'b1; step(); vec_ready = 1'b0;
    endtask

    function automatic int first_set(input logic [3:0] p);
        int f = 0;
        for (int i = 3; i >= 0; i--) if (p[i]) f = i;
        return f;
    endfunction

    logic [3:0] pend_m;
    logic [3:0] ovf_r;
    logic [2:0] pia_r;
    int         lost_m, exp_func, deliveries;
    logic       hon_r, rdy_r, retire_m;

    initial begin
        @(negedge clk); step();
        check("rst_pi_req", pi_req, 0);
        check("rst_vec_valid", vec_valid, 0);
        check("rst_ack", interval_ack, 0);
        check("rst_vec_vector", vec_vector, 0);
        check("rst_vec_func", vec_func, 0);
        check("rst_pend", pend, 0);
        check("rst_mtr_pia", mtr_pia, 0);
        check("rst_lost", lost_cnt, 0);
        RESET = 1'b0;

        // single ebox overflow at PIA 5
        cono(3'd5);
        check("t1_pia", mtr_pia, 5);
        pulse(4'b0100);
        check("t1_pend", pend, 5'b00100);
        check("t1_noreq_yet", pi_req, 0);
        step();
        check("t1_req", pi_req, 1);
        check("t1_req_pia", pi_req_pia, 5);
        honor();
        check("t1_valid", vec_valid, 1);
        check("t1_vector", vec_vector, 0);
        check("t1_func", vec_func, 2);
        step();
        check("t1_hold_valid", vec_valid, 1);
        check("t1_hold_func", vec_func, 2);
        ready();
        check("t1_pend_clr", pend, 0);
        check("t1_req_drop", pi_req, 0);
        check("t1_valid_drop", vec_valid, 0);

        // simultaneous cache + time: time first
        cono(3'd3);
        pulse(4'b1001);
        check("t2_pend", pend, 5'b01001);
        step();
        check("t2_req_pia", pi_req_pia, 3);
        honor();
        check("t2_func0", vec_func, 0);
        ready();
        check("t2_pend_left", pend, 5'b01000);
        step();
        check("t2_rereq", pi_req, 1);
        honor();
        check("t2_func3", vec_func, 3);
        ready();
        check("t2_pend_clr", pend, 0);

        // interval vector
        cono(3'd7);
        interval_done = 1'b1;
        step();
        check("t3_pend", pend, 5'b10000);
        check("t3_req", pi_req, 1);
        honor();
        check("t3_vector", vec_vector, 1);
        check("t3_func", vec_func, 0);
        ready();
        check("t3_ack", interval_ack, 1);
        check("t3_pend_masked", pend, 0);
        step();
        check("t3_ack_once", interval_ack, 0);
        for (int k = 0; k < 10; k++) begin
            check("t3_no_rereq", pi_req, 0);
            step();
        end
        interval_done = 1'b0;
        step();
        interval_done = 1'b1;
        step();
        check("t3_new_req", pi_req, 1);
        honor();
        check("t3_vector2", vec_vector, 1);
        ready();
        check("t3_ack2", interval_ack, 1);
        interval_done = 1'b0;
        step();

        // PIA 0 holds requests off but keeps pending
        cono(3'd0);
        pulse(4'b0010);
        step(); step();
        check("t4_no_req", pi_req, 0);
        check("t4_pend", pend, 5'b00010);
        cono(3'd2);
        step();
        check("t4_req", pi_req, 1);
        check("t4_req_pia", pi_req_pia, 2);
        honor();
        check("t4_func", vec_func, 1);
        ready();

        // timeout: high TIMEOUT cycles, low one, high again; honor in the gap ignored
        pulse(4'b0100);
        step();
        for (int k = 0; k < TIMEOUT; k++) begin
            check("t5_req_high", pi_req, 1);
            step();
        end
        check("t5_drop_low", pi_req, 0);
        pi_honor = 1'b1;
        step();
        pi_honor = 1'b0;
        check("t5_rereq", pi_req, 1);
        check("t5_honor_ignored", vec_valid, 0);
        honor();
        check("t5_func", vec_func, 2);
        ready();
        check("t5_pend_clr", pend, 0);

        // PIA change during VEC does not abort delivery
        pulse(4'b0001);
        step();
        honor();
        cono(3'd0);
        check("t6_valid_kept", vec_valid, 1);
        check("t6_func_kept", vec_func, 0);
        check("t6_pia_zero", mtr_pia, 0);
        ready();
        check("t6_pend_clr", pend, 0);

        // lost overflow counting
        cono(3'd0);
        pulse(4'b0001); pulse(4'b0001); pulse(4'b0001);
        check("t7_lost", lost_cnt, LOST_EN ? 2 : 0);
        cono(3'd1);
        check("t7_lost_clr", lost_cnt, 0);
        step();
        honor();
        ready();
        check("t7_pend_clr", pend, 0);

        // reset mid-handshake
        pulse(4'b0010);
        step();
        honor();
        check("t8_valid", vec_valid, 1);
        RESET = 1'b1;
        step();
        check("t8_rst_valid", vec_valid, 0);
        check("t8_rst_pend", pend, 0);
        check("t8_rst_pia", mtr_pia, 0);
        check("t8_rst_req", pi_req, 0);
        RESET = 1'b0;

        // randomized phase against a pending-set model
        pia_r = 3'($urandom_range(7, 1));
        cono(pia_r);
        check("rnd_pia", pi_req_pia, 32'(pia_r));
        pend_m = '0; lost_m = 0; exp_func = 0; deliveries = 0;
        for (int c = 0; c < 400; c++) begin
            check("rnd_pend", pend, {1'b0, pend_m});
            check("rnd_lost", lost_cnt, LOST_EN ? lost_m : 0);
            if (vec_valid) begin
                check("rnd_func", vec_func, exp_func);
                check("rnd_vector", vec_vector, 0);
            end
            for (int i = 0; i < 4; i++) ovf_r[i] = ($urandom_range(5, 0) == 0);
            hon_r = ($urandom_range(2, 0) == 0);
            rdy_r = ($urandom_range(1, 0) == 0);
            {ovf_cache, ovf_ebox, ovf_perf, ovf_time} = ovf_r;
            pi_honor  = hon_r;
            vec_ready = rdy_r;
            if (pi_req && hon_r) exp_func = first_set(pend_m);
            retire_m = vec_valid && rdy_r;
            for (int i = 0; i < 4; i++) begin
                if (ovf_r[i]) begin
                    if (pend_m[i] && !(retire_m && exp_func == i) && lost_m < 255) lost_m++;
                    pend_m[i] = 1'b1;
                end
            end
            if (retire_m) begin
                pend_m[exp_func] = ovf_r[exp_func];
                deliveries++;
            end
            step();
        end
        {ovf_cache, ovf_ebox, ovf_perf, ovf_time} = 4'b0;
        pi_honor = 1'b0; vec_ready = 1'b0;
        check("rnd_delivered", 32'(deliveries > 0), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
